// File: rtl/bnn_pkg.sv
// Shared FSM state encoding and width helpers for the binary FC classifier.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width able to hold any count 0..n inclusive.
  function automatic int sw_f(input int n);
    return clog2_f(n + 1);
  endfunction

  // Width of an index 0..n-1, never narrower than one bit.
  function automatic int cw_f(input int n);
    return (n < 2) ? 1 : clog2_f(n);
  endfunction

endpackage

// File: rtl/bnn_fc_classifier_popcount.sv
// Combinational population count of an N-bit vector.
module popcount
  import bnn_pkg::*;
#(
  parameter  int N = 196,
  localparam int W = sw_f(N)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/bnn_fc_classifier.sv
// Binary fully-connected classifier: XNOR/popcount one channel per cycle, argmax over classes.
module bnn_fc_classifier
  import bnn_pkg::*;
#(
  parameter  int IC          = 8,
  parameter  int IMG_SIZE    = 14,
  parameter  int NUM_CLASSES = 10,
  localparam int MAP         = IMG_SIZE * IMG_SIZE,
  localparam int FEAT        = IC * MAP,
  localparam int SW          = sw_f(FEAT),
  localparam int CW          = cw_f(NUM_CLASSES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            data_in_ready,
  input  logic [MAP-1:0]  img_in [0:IC-1],
  input  logic [FEAT-1:0] weights [0:NUM_CLASSES-1],
  output logic [CW-1:0]   class_out,
  output logic [SW-1:0]   score_out,
  output logic            data_out_ready
);

  localparam int KW = cw_f(IC);
  localparam int PW = sw_f(MAP);

  state_e          state_q, state_d;
  logic [MAP-1:0]  feat_q [0:IC-1];
  logic [MAP-1:0]  feat_d [0:IC-1];
  logic [CW-1:0]   c_q, c_d;
  logic [KW-1:0]   k_q, k_d;
  logic            issue_done_q, issue_done_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic            pvld_q, pvld_d;
  logic            plast_q, plast_d;
  logic            pfinal_q, pfinal_d;
  logic [CW-1:0]   pcls_q, pcls_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   best_q, best_d;
  logic [CW-1:0]   best_idx_q, best_idx_d;
  logic [CW-1:0]   class_q, class_d;
  logic [SW-1:0]   score_q, score_d;
  logic            dor_q, dor_d;

  logic [MAP-1:0]  w_sel;
  logic [MAP-1:0]  xnor_bits;
  logic [PW-1:0]   pc_cnt;
  logic [SW-1:0]   total;
  logic            new_best;
  logic            k_last;
  logic            c_last;

  assign w_sel     = weights[c_q][int'(k_q) * MAP +: MAP];
  assign xnor_bits = ~(feat_q[k_q] ^ w_sel);
  assign k_last    = (k_q == KW'(IC - 1));
  assign c_last    = (c_q == CW'(NUM_CLASSES - 1));

  popcount #(.N(MAP)) u_popcount (
    .bits  (xnor_bits),
    .count (pc_cnt)
  );

  // Class 0 always seeds the best; later classes must be strictly greater so ties keep the lower index.
  assign total    = acc_q + SW'(pc_q);
  assign new_best = (pcls_q == '0) || (total > best_q);

  always_comb begin
    state_d      = state_q;
    feat_d       = feat_q;
    c_d          = c_q;
    k_d          = k_q;
    issue_done_d = issue_done_q;
    pc_d         = pc_q;
    pvld_d       = pvld_q;
    plast_d      = plast_q;
    pfinal_d     = pfinal_q;
    pcls_d       = pcls_q;
    acc_d        = acc_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    class_d      = class_q;
    score_d      = score_q;
    dor_d        = dor_q;

    case (state_q)
      IDLE: begin
        if (data_in_ready) begin
          feat_d       = img_in;
          c_d          = '0;
          k_d          = '0;
          acc_d        = '0;
          best_d       = '0;
          best_idx_d   = '0;
          issue_done_d = 1'b0;
          pvld_d       = 1'b0;
          state_d      = ACCUM;
        end
      end

      ACCUM: begin
        if (!data_in_ready) begin
          state_d = IDLE;
          pvld_d  = 1'b0;
          dor_d   = 1'b0;
          class_d = '0;
          score_d = '0;
        end else begin
          // Issue stage: popcount of (class c, channel k) is registered before accumulation.
          pvld_d   = !issue_done_q;
          pc_d     = pc_cnt;
          plast_d  = k_last;
          pfinal_d = k_last && c_last;
          pcls_d   = c_q;
          if (!issue_done_q) begin
            if (k_last) begin
              k_d = '0;
              if (c_last) issue_done_d = 1'b1;
              else        c_d = c_q + CW'(1);
            end else begin
              k_d = k_q + KW'(1);
            end
          end

          // Accumulate stage: close out a class on its last channel.
          if (pvld_q) begin
            if (plast_q) begin
              acc_d = '0;
              if (new_best) begin
                best_d     = total;
                best_idx_d = pcls_q;
              end
              if (pfinal_q) begin
                state_d = DONE;
                pvld_d  = 1'b0;
                dor_d   = 1'b1;
                class_d = new_best ? pcls_q : best_idx_q;
                score_d = new_best ? total  : best_q;
              end
            end else begin
              acc_d = total;
            end
          end
        end
      end

      DONE: begin
        if (!data_in_ready) begin
          state_d = IDLE;
          dor_d   = 1'b0;
          class_d = '0;
          score_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        dor_d   = 1'b0;
        class_d = '0;
        score_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < IC; i++) feat_q[i] <= '0;
      c_q          <= '0;
      k_q          <= '0;
      issue_done_q <= 1'b0;
      pc_q         <= '0;
      pvld_q       <= 1'b0;
      plast_q      <= 1'b0;
      pfinal_q     <= 1'b0;
      pcls_q       <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      class_q      <= '0;
      score_q      <= '0;
      dor_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      feat_q       <= feat_d;
      c_q          <= c_d;
      k_q          <= k_d;
      issue_done_q <= issue_done_d;
      pc_q         <= pc_d;
      pvld_q       <= pvld_d;
      plast_q      <= plast_d;
      pfinal_q     <= pfinal_d;
      pcls_q       <= pcls_d;
      acc_q        <= acc_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      class_q      <= class_d;
      score_q      <= score_d;
      dor_q        <= dor_d;
    end
  end

  assign class_out      = class_q;
  assign score_out      = score_q;
  assign data_out_ready = dor_q;

endmodule

// File: tb/tb_bnn_fc_classifier.sv
// Self-checking bench for bnn_fc_classifier: table vectors, random vectors vs. argmax model, abort/reset sequences.
module tb_bnn_fc_classifier;
  import bnn_pkg::*;

  localparam int IC   = 8;
  localparam int IMG  = 14;
  localparam int NC   = 10;
  localparam int MAP  = IMG * IMG;
  localparam int FEAT = IC * MAP;
  localparam int SW   = sw_f(FEAT);
  localparam int CW   = cw_f(NC);
  localparam int LAT  = NC * IC + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            data_in_ready;
  logic [MAP-1:0]  img_in [0:IC-1];
  logic [FEAT-1:0] weights [0:NC-1];
  logic [CW-1:0]   class_out;
  logic [SW-1:0]   score_out;
  logic            data_out_ready;

  int n_pass = 0;
  int n_total = 0;

  bnn_fc_classifier #(.IC(IC), .IMG_SIZE(IMG), .NUM_CLASSES(NC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_ready  (data_in_ready),
    .img_in         (img_in),
    .weights        (weights),
    .class_out      (class_out),
    .score_out      (score_out),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    bit    img_ones;
    bit    base_w;
    int    sp_idx;
    bit    sp_w;
    int    exp_cls;
    int    exp_sc;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic fill_img_const(input bit v);
    for (int k = 0; k < IC; k++) img_in[k] = v ? '1 : '0;
  endtask

  task automatic fill_img_rand();
    for (int k = 0; k < IC; k++)
      for (int i = 0; i < MAP; i++) img_in[k][i] = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_w_rand(input int c);
    for (int i = 0; i < FEAT; i++) weights[c][i] = 1'($urandom_range(0, 1));
  endtask

  // Reference: score = number of agreeing bits over the whole flattened feature; first maximum wins.
  function automatic void model(input logic [MAP-1:0] im [0:IC-1], output int cls, output int sc);
    logic [FEAT-1:0] flat;
    int s;
    for (int k = 0; k < IC; k++) flat[k*MAP +: MAP] = im[k];
    sc = -1;
    cls = 0;
    for (int c = 0; c < NC; c++) begin
      s = FEAT - $countones(flat ^ weights[c]);
      if (s > sc) begin
        sc = s;
        cls = c;
      end
    end
  endfunction

  task automatic run(input string nm, input bit scramble, input int exp_cls, input int exp_sc);
    int n;
    int lat;
    int quiet;
    data_in_ready = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    quiet = 1;
    for (n = 1; n <= 200; n++) begin
      if (scramble) fill_img_rand();
      @(posedge clk); #1;
      if (data_out_ready) begin
        lat = n;
        break;
      end
      if (class_out != '0 || score_out != '0) quiet = 0;
    end
    check({nm, "_latency"}, lat, LAT);
    check({nm, "_quiet_accum"}, quiet, 1);
    check({nm, "_class"}, int'(class_out), exp_cls);
    check({nm, "_score"}, int'(score_out), exp_sc);
  endtask

  task automatic hold_and_drop(input string nm, input int exp_cls, input int exp_sc);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_hold_class"}, int'(class_out), exp_cls);
    check({nm, "_hold_score"}, int'(score_out), exp_sc);
    data_in_ready = 1'b0;
    @(posedge clk); #1;
    check({nm, "_drop_ready"}, int'(data_out_ready), 0);
    check({nm, "_drop_out"}, int'(class_out) + int'(score_out), 0);
  endtask

  vec_t tbl [4];
  logic [MAP-1:0] cap [0:IC-1];
  int mc, ms;

  initial begin
    tbl[0] = '{"ones_w3",   1'b1, 1'b0, 3, 1'b1, 3, FEAT};
    tbl[1] = '{"zeros_w9",  1'b0, 1'b1, 9, 1'b0, 9, FEAT};
    tbl[2] = '{"all_miss",  1'b1, 1'b0, 0, 1'b0, 0, 0};
    tbl[3] = '{"all_tie",   1'b0, 1'b0, 5, 1'b0, 0, FEAT};

    rst_n = 1'b0;
    data_in_ready = 1'b0;
    fill_img_const(1'b0);
    for (int c = 0; c < NC; c++) weights[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(data_out_ready), 0);
    check("reset_out", int'(class_out) + int'(score_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      fill_img_const(tbl[t].img_ones);
      for (int c = 0; c < NC; c++) weights[c] = tbl[t].base_w ? '1 : '0;
      weights[tbl[t].sp_idx] = tbl[t].sp_w ? '1 : '0;
      run(tbl[t].nm, 1'b0, tbl[t].exp_cls, tbl[t].exp_sc);
      hold_and_drop(tbl[t].nm, tbl[t].exp_cls, tbl[t].exp_sc);
    end

    // Identical random weights for every class: tie resolves to class 0.
    fill_w_rand(0);
    for (int c = 1; c < NC; c++) weights[c] = weights[0];
    fill_img_rand();
    model(img_in, mc, ms);
    check("tie_model_cls", mc, 0);
    run("rand_tie", 1'b0, 0, ms);
    hold_and_drop("rand_tie", 0, ms);

    // Random weights and image, image scrambled after capture.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NC; c++) fill_w_rand(c);
      fill_img_rand();
      cap = img_in;
      model(cap, mc, ms);
      run("rand_scramble", 1'b1, mc, ms);
      hold_and_drop("rand_scramble", mc, ms);
    end

    // Abort mid-accumulation, then a full rerun.
    for (int c = 0; c < NC; c++) fill_w_rand(c);
    fill_img_rand();
    model(img_in, mc, ms);
    data_in_ready = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    data_in_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", int'(data_out_ready), 0);
    check("abort_out", int'(class_out) + int'(score_out), 0);
    run("after_abort", 1'b0, mc, ms);

    // Asynchronous reset while DONE is holding results.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", int'(data_out_ready), 0);
    check("async_rst_out", int'(class_out) + int'(score_out), 0);
    data_in_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-accumulation with data_in_ready held high, then restart.
    data_in_ready = 1'b1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(data_out_ready), 0);
    #1 rst_n = 1'b1;
    run("after_mid_rst", 1'b0, mc, ms);
    hold_and_drop("after_mid_rst", mc, ms);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
